// File: rtl/obstacle_spawner.sv
// Obstacle spawner: NUM_OBS left-scrolling obstacle slots with LFSR-spaced spawning,
// a velocity ramp and an IDLE/RUN/FROZEN control state machine.
module obstacle_spawner #(
    parameter int          NUM_OBS       = 3,
    parameter int          X_W           = 10,
    parameter int          V_W           = 5,
    parameter int          SPAWN_X       = 640,
    parameter int          VEL_INIT      = 10,
    parameter int          VEL_STEP      = 1,
    parameter int          VEL_MAX       = 20,
    parameter int          SPEEDUP_TICKS = 600,
    parameter int          MIN_GAP       = 180,
    parameter logic [7:0]  GAP_RAND_MASK = 8'h7F,
    parameter int          DIST_W        = 12,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   game_tick,
    input  logic                   start,
    input  logic                   game_over,
    output logic [NUM_OBS*X_W-1:0] obstacle_x,
    output logic [NUM_OBS-1:0]     obstacle_active,
    output logic [V_W-1:0]         velocity,
    output logic [1:0]             state,
    output logic                   spawn
);

    localparam int                TC_W      = (SPEEDUP_TICKS > 1) ? $clog2(SPEEDUP_TICKS) : 1;
    localparam logic [X_W-1:0]    SPAWN_XV  = X_W'(SPAWN_X);
    localparam logic [V_W-1:0]    VEL_INITV = V_W'(VEL_INIT);
    localparam logic [V_W-1:0]    VEL_MAXV  = V_W'(VEL_MAX);
    localparam logic [V_W:0]      VEL_STEPV = (V_W+1)'(VEL_STEP);
    localparam logic [DIST_W-1:0] MIN_GAPV  = DIST_W'(MIN_GAP);
    localparam logic [TC_W-1:0]   TC_LAST   = TC_W'(SPEEDUP_TICKS - 1);
    localparam logic [DIST_W-1:0] GAP_RESET = MIN_GAPV + DIST_W'(LFSR_SEED[7:0] & GAP_RAND_MASK);

    if (NUM_OBS < 1) begin : g_chk_num
        $error("obstacle_spawner: NUM_OBS must be at least 1");
    end
    if (V_W > X_W) begin : g_chk_vw
        $error("obstacle_spawner: V_W must not exceed X_W");
    end
    if (SPAWN_X >= (1 << X_W)) begin : g_chk_spawn
        $error("obstacle_spawner: SPAWN_X does not fit in X_W bits");
    end
    if (MIN_GAP + 255 >= (1 << DIST_W)) begin : g_chk_gap
        $error("obstacle_spawner: MIN_GAP+255 does not fit in DIST_W bits");
    end
    if (VEL_MAX >= (1 << V_W) || VEL_INIT > VEL_MAX) begin : g_chk_vel
        $error("obstacle_spawner: VEL_MAX/VEL_INIT out of range for V_W");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FROZEN = 2'b10
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_OBS*X_W-1:0]   x_q, x_d;
    logic [NUM_OBS-1:0]       act_q, act_d;
    logic [V_W-1:0]           vel_q, vel_d;
    logic [DIST_W-1:0]        dist_q, dist_d;
    logic [TC_W-1:0]          tick_q, tick_d;
    logic [15:0]              lfsr_q, lfsr_d;
    logic [DIST_W-1:0]        gap_q, gap_d;
    logic                     spawn_q, spawn_d;

    logic                     enter_run;
    logic                     tick_run;
    logic                     found;
    logic [X_W-1:0]           cur_x;
    logic [DIST_W:0]          dist_sum;
    logic [DIST_W-1:0]        dist_next;
    logic [V_W:0]             vel_sum;
    logic [15:0]              lfsr_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= {NUM_OBS{SPAWN_XV}};
            act_q   <= '0;
            vel_q   <= VEL_INITV;
            dist_q  <= '0;
            tick_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            gap_q   <= GAP_RESET;
            spawn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            act_q   <= act_d;
            vel_q   <= vel_d;
            dist_q  <= dist_d;
            tick_q  <= tick_d;
            lfsr_q  <= lfsr_d;
            gap_q   <= gap_d;
            spawn_q <= spawn_d;
        end
    end

    // Movement and spawning both use the pre-update velocity; a slot freed by
    // movement is already a spawn candidate within the same tick.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        act_d     = act_q;
        vel_d     = vel_q;
        dist_d    = dist_q;
        tick_d    = tick_q;
        lfsr_d    = lfsr_q;
        gap_d     = gap_q;
        spawn_d   = 1'b0;
        enter_run = 1'b0;
        tick_run  = 1'b0;
        found     = 1'b0;
        cur_x     = '0;
        dist_sum  = '0;
        dist_next = '0;
        vel_sum   = '0;
        lfsr_adv  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        unique case (state_q)
            IDLE:    if (start) enter_run = 1'b1;
            RUN: begin
                if (game_over) begin
                    state_d = FROZEN;
                end else if (game_tick) begin
                    tick_run = 1'b1;
                end
            end
            FROZEN:  if (start) enter_run = 1'b1;
            default: state_d = IDLE;
        endcase

        if (enter_run) begin
            state_d  = RUN;
            x_d      = {NUM_OBS{SPAWN_XV}};
            act_d    = '0;
            act_d[0] = 1'b1;
            vel_d    = VEL_INITV;
            dist_d   = '0;
            tick_d   = '0;
            spawn_d  = 1'b1;
        end

        if (tick_run) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                cur_x = x_q[i*X_W +: X_W];
                if (act_q[i]) begin
                    if (cur_x <= X_W'(vel_q)) begin
                        act_d[i]            = 1'b0;
                        x_d[i*X_W +: X_W]   = SPAWN_XV;
                    end else begin
                        x_d[i*X_W +: X_W]   = cur_x - X_W'(vel_q);
                    end
                end
            end

            dist_sum  = {1'b0, dist_q} + (DIST_W+1)'(vel_q);
            dist_next = dist_sum[DIST_W] ? {DIST_W{1'b1}} : dist_sum[DIST_W-1:0];
            dist_d    = dist_next;

            if (dist_next >= gap_q && !(&act_d)) begin
                for (int i = 0; i < NUM_OBS; i++) begin
                    if (!found && !act_d[i]) begin
                        act_d[i]          = 1'b1;
                        x_d[i*X_W +: X_W] = SPAWN_XV;
                        found             = 1'b1;
                    end
                end
                spawn_d = 1'b1;
                dist_d  = '0;
                lfsr_d  = lfsr_adv;
                gap_d   = MIN_GAPV + DIST_W'(lfsr_adv[7:0] & GAP_RAND_MASK);
            end

            if (tick_q == TC_LAST) begin
                tick_d  = '0;
                vel_sum = {1'b0, vel_q} + VEL_STEPV;
                vel_d   = (vel_sum > {1'b0, VEL_MAXV}) ? VEL_MAXV : vel_sum[V_W-1:0];
            end else begin
                tick_d  = tick_q + 1'b1;
            end
        end
    end

    assign obstacle_x      = x_q;
    assign obstacle_active = act_q;
    assign velocity        = vel_q;
    assign state           = state_q;
    assign spawn           = spawn_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: two instances (fixed gap and LFSR-random gap) driven by
// shared directed stimulus, checked every cycle against a behavioural game model.
module tb_obstacle_spawner;

    localparam int SPAWN_X  = 640;
    localparam int VEL_INIT = 10;
    localparam int MIN_GAP  = 200;
    localparam int DIST_MAX = 4095;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        game_tick = 1'b0;
    logic        start = 1'b0;
    logic        game_over = 1'b0;

    logic [19:0] ox_a, ox_b;
    logic [1:0]  oa_a, oa_b;
    logic [4:0]  ov_a, ov_b;
    logic [1:0]  os_a, os_b;
    logic        osp_a, osp_b;

    int checks = 0;
    int errors = 0;

    // Per-instance configuration: index 0 = fixed gap / fast ramp, index 1 = random gap.
    int c_mask [2] = '{0, 127};
    int c_sp   [2] = '{100, 600};
    int c_step [2] = '{2, 1};
    int c_vmax [2] = '{14, 20};

    int          m_x     [2][2];
    bit          m_act   [2][2];
    int          m_vel   [2];
    int          m_dist  [2];
    int          m_tick  [2];
    int          m_gap   [2];
    int          m_state [2];
    bit          m_spawn [2];
    int unsigned m_lfsr  [2];

    obstacle_spawner #(
        .NUM_OBS(2), .X_W(10), .V_W(5), .SPAWN_X(SPAWN_X), .VEL_INIT(VEL_INIT),
        .VEL_STEP(2), .VEL_MAX(14), .SPEEDUP_TICKS(100), .MIN_GAP(MIN_GAP),
        .GAP_RAND_MASK(8'h00), .DIST_W(12), .LFSR_SEED(16'hACE1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .game_tick(game_tick), .start(start), .game_over(game_over),
        .obstacle_x(ox_a), .obstacle_active(oa_a), .velocity(ov_a), .state(os_a), .spawn(osp_a)
    );

    obstacle_spawner #(
        .NUM_OBS(2), .X_W(10), .V_W(5), .SPAWN_X(SPAWN_X), .VEL_INIT(VEL_INIT),
        .VEL_STEP(1), .VEL_MAX(20), .SPEEDUP_TICKS(600), .MIN_GAP(MIN_GAP),
        .GAP_RAND_MASK(8'h7F), .DIST_W(12), .LFSR_SEED(16'hACE1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .game_tick(game_tick), .start(start), .game_over(game_over),
        .obstacle_x(ox_b), .obstacle_active(oa_b), .velocity(ov_b), .state(os_b), .spawn(osp_b)
    );

    always #5 clk = ~clk;

    function automatic int unsigned lfsrAdvance(input int unsigned v);
        return (v & 1) ? ((v >> 1) ^ 32'hB400) : (v >> 1);
    endfunction

    task automatic modelReset(input int k);
        m_state[k] = 0;
        m_vel[k]   = VEL_INIT;
        m_dist[k]  = 0;
        m_tick[k]  = 0;
        m_spawn[k] = 0;
        m_lfsr[k]  = 32'hACE1;
        m_gap[k]   = MIN_GAP + (32'hE1 & c_mask[k]);
        for (int i = 0; i < 2; i++) begin
            m_x[k][i]   = SPAWN_X;
            m_act[k][i] = 0;
        end
    endtask

    // Game rules: stop/start control, scroll, spacing-driven spawn, periodic speed-up.
    task automatic modelStep(input int k, input bit t, input bit s, input bit g);
        int slot;
        m_spawn[k] = 0;
        if (m_state[k] == 1) begin
            if (g) begin
                m_state[k] = 2;
            end else if (t) begin
                for (int i = 0; i < 2; i++) begin
                    if (m_act[k][i]) begin
                        if (m_x[k][i] <= m_vel[k]) begin
                            m_act[k][i] = 0;
                            m_x[k][i]   = SPAWN_X;
                        end else begin
                            m_x[k][i] = m_x[k][i] - m_vel[k];
                        end
                    end
                end
                m_dist[k] = m_dist[k] + m_vel[k];
                if (m_dist[k] > DIST_MAX) m_dist[k] = DIST_MAX;
                slot = -1;
                for (int i = 0; i < 2; i++) if (slot < 0 && !m_act[k][i]) slot = i;
                if (m_dist[k] >= m_gap[k] && slot >= 0) begin
                    m_act[k][slot] = 1;
                    m_x[k][slot]   = SPAWN_X;
                    m_spawn[k]     = 1;
                    m_dist[k]      = 0;
                    m_lfsr[k]      = lfsrAdvance(m_lfsr[k]);
                    m_gap[k]       = MIN_GAP + int'(m_lfsr[k] & 255 & c_mask[k]);
                end
                if (m_tick[k] == c_sp[k] - 1) begin
                    m_tick[k] = 0;
                    m_vel[k]  = (m_vel[k] + c_step[k] > c_vmax[k]) ? c_vmax[k] : m_vel[k] + c_step[k];
                end else begin
                    m_tick[k] = m_tick[k] + 1;
                end
            end
        end else if (s) begin
            m_state[k] = 1;
            m_vel[k]   = VEL_INIT;
            m_dist[k]  = 0;
            m_tick[k]  = 0;
            m_spawn[k] = 1;
            for (int i = 0; i < 2; i++) begin
                m_x[k][i]   = SPAWN_X;
                m_act[k][i] = (i == 0);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) modelReset(k);
            end else begin
                for (int k = 0; k < 2; k++) modelStep(k, game_tick, start, game_over);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareInst(input int k, input logic [19:0] ox, input logic [1:0] oa,
                               input logic [4:0] ov, input logic [1:0] os, input logic osp);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("inst%0d_x%0d", k, i), int'(ox[i*10 +: 10]), m_x[k][i]);
            checkOutput($sformatf("inst%0d_active%0d", k, i), int'(oa[i]), int'(m_act[k][i]));
        end
        checkOutput($sformatf("inst%0d_velocity", k), int'(ov), m_vel[k]);
        checkOutput($sformatf("inst%0d_state", k), int'(os), m_state[k]);
        checkOutput($sformatf("inst%0d_spawn", k), int'(osp), int'(m_spawn[k]));
    endtask

    always @(negedge clk) begin
        compareInst(0, ox_a, oa_a, ov_a, os_a, osp_a);
        compareInst(1, ox_b, oa_b, ov_b, os_b, osp_b);
    end

    // Drives one cycle of inputs from a falling edge; outputs are valid on return.
    task automatic applyStimulus(input bit t, input bit s, input bit g);
        game_tick = t;
        start     = s;
        game_over = g;
        @(negedge clk);
        game_tick = 1'b0;
        start     = 1'b0;
        game_over = 1'b0;
    endtask

    task automatic doTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, int'(os_a), 0);
        checkOutput({tag, "_active"}, int'(oa_a), 0);
        checkOutput({tag, "_x0"}, int'(ox_a[9:0]), 640);
        checkOutput({tag, "_x1"}, int'(ox_a[19:10]), 640);
        checkOutput({tag, "_vel"}, int'(ov_a), 10);
        checkOutput({tag, "_spawn"}, int'(osp_a), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkResetValues("rst");
        rst_n = 1'b1;
        @(negedge clk);
        doTicks(5);
        checkResetValues("idle_ticks");

        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("start_state", int'(os_a), 1);
        checkOutput("start_active", int'(oa_a), 1);
        checkOutput("start_x0", int'(ox_a[9:0]), 640);
        checkOutput("start_spawn", int'(osp_a), 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("start_spawn_drop", int'(osp_a), 0);

        doTicks(5);
        checkOutput("t5_x0", int'(ox_a[9:0]), 590);
        doTicks(15);
        checkOutput("t20_x0", int'(ox_a[9:0]), 440);
        checkOutput("t20_x1", int'(ox_a[19:10]), 640);
        checkOutput("t20_active", int'(oa_a), 3);
        checkOutput("t20_spawn", int'(osp_a), 1);
        checkOutput("t20_b_active", int'(oa_b), 1);
        doTicks(9);
        checkOutput("t29_b_active", int'(oa_b), 1);
        doTicks(1);
        checkOutput("t30_b_active", int'(oa_b), 3);
        checkOutput("t30_b_x1", int'(ox_b[19:10]), 640);
        checkOutput("t30_b_spawn", int'(osp_b), 1);
        doTicks(10);
        checkOutput("t40_spawn", int'(osp_a), 0);
        checkOutput("t40_active", int'(oa_a), 3);
        doTicks(23);
        checkOutput("t63_x0", int'(ox_a[9:0]), 10);
        doTicks(1);
        checkOutput("t64_x0", int'(ox_a[9:0]), 640);
        checkOutput("t64_active", int'(oa_a), 3);
        checkOutput("t64_spawn", int'(osp_a), 1);
        checkOutput("t64_x1", int'(ox_a[19:10]), 200);

        doTicks(35);
        checkOutput("t99_vel", int'(ov_a), 10);
        doTicks(1);
        checkOutput("t100_vel", int'(ov_a), 12);
        doTicks(100);
        checkOutput("t200_vel", int'(ov_a), 14);
        doTicks(100);
        checkOutput("t300_vel", int'(ov_a), 14);

        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("freeze_state", int'(os_a), 2);
        doTicks(10);
        checkOutput("frozen_state", int'(os_a), 2);
        checkOutput("frozen_b_state", int'(os_b), 2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("restart_state", int'(os_a), 1);
        checkOutput("restart_active", int'(oa_a), 1);
        checkOutput("restart_x0", int'(ox_a[9:0]), 640);
        checkOutput("restart_vel", int'(ov_a), 10);

        doTicks(3);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("async_rst");
        checkOutput("async_rst_b_state", int'(os_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
